// File: rtl/gpio_input_debouncer_if.sv
// ---------------------------------------------------------------------------
// gpio_input_debouncer_if
// Bundles the raw GPIO inputs and the debounced outputs of
// gpio_input_debouncer.
//   w_SwitchesRaw [9:0] raw slide switches, asynchronous, active-high
//   w_KeysRaw     [3:0] raw pushbuttons, asynchronous, active-low
//   w_Switches    [9:0] debounced switch levels, active-high
//   w_Keys        [3:0] debounced key levels, active-high (1 = pressed)
//   w_KeyPressed  [3:0] one-cycle pulse per debounced key press
//   w_KeyReleased [3:0] one-cycle pulse per debounced key release
// master: the side that owns the raw pins and consumes the debounced levels.
// slave : the debouncer itself.
// ---------------------------------------------------------------------------
interface gpio_input_debouncer_if;
  logic [9:0] w_SwitchesRaw;
  logic [3:0] w_KeysRaw;
  logic [9:0] w_Switches;
  logic [3:0] w_Keys;
  logic [3:0] w_KeyPressed;
  logic [3:0] w_KeyReleased;

  modport master (
    output w_SwitchesRaw,
    output w_KeysRaw,
    input  w_Switches,
    input  w_Keys,
    input  w_KeyPressed,
    input  w_KeyReleased
  );

  modport slave (
    input  w_SwitchesRaw,
    input  w_KeysRaw,
    output w_Switches,
    output w_Keys,
    output w_KeyPressed,
    output w_KeyReleased
  );
endinterface

// File: rtl/gpio_input_debouncer.sv
// ---------------------------------------------------------------------------
// gpio_input_debouncer
// Synchronizes and debounces 10 slide switches and 4 pushbuttons. An output
// bit only changes after its synchronized input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; key press/release edges of the
// debounced levels are reported as one-cycle pulses.
// Ports:
//   CoreClock  single clock, everything updates on its rising edge
//   Reset      synchronous, active-high
//   gpio       gpio_input_debouncer_if.slave (raw inputs, debounced outputs)
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles required before an output changes (>= 2)
// ---------------------------------------------------------------------------
module gpio_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                         CoreClock,
  input  logic                         Reset,
  gpio_input_debouncer_if.slave        gpio
);

  localparam int NUM_SW   = 10;
  localparam int NUM_KEY  = 4;
  localparam int NUM_BITS = NUM_SW + NUM_KEY;
  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit map of the combined vector: [9:0] switches, [13:10] keys.
  // Keys idle high on the pins, so their synchronizer stages reset to 1.
  localparam logic [NUM_BITS-1:0] SYNC_IDLE = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};

  logic [NUM_BITS-1:0] sync1_reg;
  logic [NUM_BITS-1:0] sync2_reg;
  logic [NUM_BITS-1:0] sample;
  logic [NUM_BITS-1:0] stable_vec;
  logic [NUM_BITS-1:0] flip_vec;
  logic [NUM_KEY-1:0]  pressed_reg;
  logic [NUM_KEY-1:0]  released_reg;
  logic [NUM_KEY-1:0]  pressed_next;
  logic [NUM_KEY-1:0]  released_next;

  // Two-flop synchronizer: the only logic that touches the raw pins.
  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      sync1_reg <= SYNC_IDLE;
      sync2_reg <= SYNC_IDLE;
    end else begin
      sync1_reg <= {gpio.w_KeysRaw, gpio.w_SwitchesRaw};
      sync2_reg <= sync1_reg;
    end
  end

  // Everything downstream is active-high: invert the key bits here.
  assign sample = {~sync2_reg[NUM_BITS-1:NUM_SW], sync2_reg[NUM_SW-1:0]};

  generate
    for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_bit
      logic             stable_reg;
      logic             stable_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             flip;

      // Any sample that agrees with the stable level restarts the count, so
      // a glitch shorter than DEBOUNCE_CYCLES leaves no trace behind.
      always_comb begin
        cnt_next    = '0;
        stable_next = stable_reg;
        flip        = 1'b0;
        if (sample[gi] != stable_reg) begin
          if (cnt_reg == CNT_MAX) begin
            stable_next = sample[gi];
            flip        = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge CoreClock) begin
        if (Reset) begin
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          stable_reg <= stable_next;
          cnt_reg    <= cnt_next;
        end
      end

      assign stable_vec[gi] = stable_reg;
      assign flip_vec[gi]   = flip;
    end
  endgenerate

  // Pulses are registered on the same edge that updates the stable level,
  // so a pulse coincides with the first cycle of the new w_Keys value.
  always_comb begin
    pressed_next  = flip_vec[NUM_BITS-1:NUM_SW] &  sample[NUM_BITS-1:NUM_SW];
    released_next = flip_vec[NUM_BITS-1:NUM_SW] & ~sample[NUM_BITS-1:NUM_SW];
  end

  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      pressed_reg  <= '0;
      released_reg <= '0;
    end else begin
      pressed_reg  <= pressed_next;
      released_reg <= released_next;
    end
  end

  assign gpio.w_Switches    = stable_vec[NUM_SW-1:0];
  assign gpio.w_Keys        = stable_vec[NUM_BITS-1:NUM_SW];
  assign gpio.w_KeyPressed  = pressed_reg;
  assign gpio.w_KeyReleased = released_reg;

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_gpio_input_debouncer
// Drives gpio_input_debouncer (DEBOUNCE_CYCLES = 4) with directed and random
// switch/key activity. Each driven cycle pushes the expected outputs of the
// following edge into a queue; a monitor pops and compares after every edge.
// ---------------------------------------------------------------------------
module tb_gpio_input_debouncer;
  localparam int D = 4;

  typedef struct packed {
    logic [9:0] sw;
    logic [3:0] keys;
    logic [3:0] pressed;
    logic [3:0] released;
  } exp_t;

  logic CoreClock = 1'b0;
  logic Reset     = 1'b1;
  gpio_input_debouncer_if g();

  gpio_input_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .CoreClock (CoreClock),
    .Reset     (Reset),
    .gpio      (g)
  );

  always #5 CoreClock = ~CoreClock;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  exp_t exp_q[$];

  // Reference model state (active-high view of every bit).
  logic [13:0] m_pipe0 = '0;
  logic [13:0] m_pipe1 = '0;
  logic [13:0] m_stable = '0;
  logic [13:0] m_hist[$];

  logic [9:0] sw_raw   = '0;
  logic [3:0] keys_raw = 4'hF;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  // Expected outputs after the coming edge. An output bit takes the
  // synchronized value once the last D samples since reset all disagreed
  // with it; samples reach the comparison two edges after the pins.
  function automatic exp_t model_edge(input logic rst, input logic [9:0] sw, input logic [3:0] keys);
    exp_t        e;
    logic [13:0] smp;
    logic [13:0] new_stable;
    e = '0;
    if (rst) begin
      m_pipe0  = '0;
      m_pipe1  = '0;
      m_stable = '0;
      m_hist.delete();
    end else begin
      smp     = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = {~keys, sw};
      m_hist.push_back(smp);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      new_stable = m_stable;
      for (int b = 0; b < 14; b++) begin
        bit all_differ;
        all_differ = (m_hist.size() == D);
        foreach (m_hist[j]) if (m_hist[j][b] == m_stable[b]) all_differ = 0;
        if (all_differ) new_stable[b] = ~m_stable[b];
      end
      for (int k = 0; k < 4; k++) begin
        e.pressed[k]  = !m_stable[10+k] &&  new_stable[10+k];
        e.released[k] =  m_stable[10+k] && !new_stable[10+k];
      end
      m_stable = new_stable;
    end
    e.sw   = m_stable[9:0];
    e.keys = m_stable[13:10];
    return e;
  endfunction

  task automatic step(input logic rst);
    @(negedge CoreClock);
    Reset           = rst;
    g.w_SwitchesRaw = sw_raw;
    g.w_KeysRaw     = keys_raw;
    exp_q.push_back(model_edge(rst, sw_raw, keys_raw));
  endtask

  // Monitor: one expected record per driven edge.
  exp_t mon_e;
  always @(posedge CoreClock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("w_Switches",    g.w_Switches,              mon_e.sw);
      check("w_Keys",        {6'd0, g.w_Keys},          {6'd0, mon_e.keys});
      check("w_KeyPressed",  {6'd0, g.w_KeyPressed},    {6'd0, mon_e.pressed});
      check("w_KeyReleased", {6'd0, g.w_KeyReleased},   {6'd0, mon_e.released});
    end
  end

  int lat;
  int mode_calm;

  initial begin
    g.w_SwitchesRaw = '0;
    g.w_KeysRaw     = 4'hF;

    // Reset then idle.
    repeat (3) step(1'b1);
    repeat (20) step(1'b0);

    // Switch 3 rises and is held; output expected on the 6th edge.
    sw_raw[3] = 1'b1;
    step(1'b0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0);
      if (lat == 0 && g.w_Switches[3]) lat = i;
    end
    check("sw3_latency_edges", 10'(lat), 10'd6);

    // Key 0: short 3-cycle press (ignored), then a real press and release.
    keys_raw[0] = 1'b0; repeat (3) step(1'b0);
    keys_raw[0] = 1'b1; repeat (8) step(1'b0);
    keys_raw[0] = 1'b0; repeat (10) step(1'b0);
    keys_raw[0] = 1'b1; repeat (10) step(1'b0);

    // Key 2 bounces every 2 cycles, then settles pressed, then released.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) keys_raw[2] = ~keys_raw[2];
      step(1'b0);
    end
    keys_raw[2] = 1'b0; repeat (10) step(1'b0);
    keys_raw[2] = 1'b1; repeat (10) step(1'b0);

    // Key 1 held through a reset that lands mid-count.
    keys_raw[1] = 1'b0; repeat (2) step(1'b0);
    repeat (2) step(1'b1);
    repeat (10) step(1'b0);
    keys_raw[1] = 1'b1; repeat (10) step(1'b0);

    // Random phase: alternating bouncy and calm stretches, rare resets.
    mode_calm = 1;
    for (int c = 0; c < 2000; c++) begin
      if (c % 60 == 0) mode_calm = $urandom_range(0, 1);
      for (int b = 0; b < 10; b++)
        if ($urandom_range(0, mode_calm ? 39 : 2) == 0) sw_raw[b] = ~sw_raw[b];
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, mode_calm ? 39 : 2) == 0) keys_raw[b] = ~keys_raw[b];
      step($urandom_range(0, 299) == 0);
    end

    // Drain the scoreboard with a bounded wait.
    @(negedge CoreClock);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CoreClock);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
